// File: rtl/mux_cfg_pkg.sv
// Shared definitions for the pin-mux configuration loader: opcodes, parser
// states and the layout of the SET value byte.
package mux_cfg_pkg;

  localparam logic [7:0] OP_SET    = 8'h01;
  localparam logic [7:0] OP_COMMIT = 8'h02;
  localparam logic [7:0] OP_CLEAR  = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GET_IDX = 2'd1,
    ST_GET_VAL = 2'd2,
    ST_COMMIT  = 2'd3
  } state_e;

  localparam int VAL_EN_BIT  = 7;
  localparam int VAL_SRC_MSB = 6;
  localparam int VAL_SRC_LSB = 0;

endpackage

// File: rtl/mux_cfg_loader.sv
// Byte-stream command parser that builds a shadow pin-mux table and copies it
// atomically into the active selectors/enables on COMMIT.
module mux_cfg_loader
  import mux_cfg_pkg::*;
#(
  parameter int INPUT_COUNT    = 16,
  parameter int OUTPUT_COUNT   = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  localparam int SEL_WIDTH     = $clog2(INPUT_COUNT)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        rx_data,
  input  logic                              rx_valid,
  output logic                              rx_ready,
  output logic [SEL_WIDTH*OUTPUT_COUNT-1:0] selectors,
  output logic [OUTPUT_COUNT-1:0]           enabled_out,
  output logic                              cmd_done,
  output logic                              cmd_err,
  output logic                              dirty
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0] OUT_LIM = 9'(OUTPUT_COUNT);
  localparam logic [7:0] IN_LIM  = 8'(INPUT_COUNT);

  state_e                            state_q, state_d;
  logic [7:0]                        idx_q, idx_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [SEL_WIDTH*OUTPUT_COUNT-1:0] shadow_sel_q, shadow_sel_d;
  logic [OUTPUT_COUNT-1:0]           shadow_en_q, shadow_en_d;
  logic [SEL_WIDTH*OUTPUT_COUNT-1:0] act_sel_q, act_sel_d;
  logic [OUTPUT_COUNT-1:0]           act_en_q, act_en_d;
  logic                              dirty_q, dirty_d;
  logic                              done_q, done_d;
  logic                              err_q, err_d;
  logic                              ready_q, ready_d;
  logic                              accept_s;
  logic                              in_range_s;
  logic [6:0]                        src_s;

  assign accept_s   = rx_valid & ready_q;
  assign src_s      = rx_data[VAL_SRC_MSB:VAL_SRC_LSB];
  assign in_range_s = ({1'b0, idx_q} < OUT_LIM) && ({1'b0, src_s} < IN_LIM);

  // Parser next-state, shadow/active table updates and status pulses.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    shadow_sel_d = shadow_sel_q;
    shadow_en_d  = shadow_en_q;
    act_sel_d    = act_sel_q;
    act_en_d     = act_en_q;
    dirty_d      = dirty_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (accept_s) begin
          case (rx_data)
            OP_SET:    state_d = ST_GET_IDX;
            OP_COMMIT: state_d = ST_COMMIT;
            OP_CLEAR: begin
              shadow_sel_d = '0;
              shadow_en_d  = '0;
              dirty_d      = 1'b1;
              done_d       = 1'b1;
            end
            default:   err_d = 1'b1;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GET_IDX: begin
        if (accept_s) begin
          idx_d   = rx_data;
          cnt_d   = '0;
          state_d = ST_GET_VAL;
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GET_VAL: begin
        if (accept_s) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (in_range_s) begin
            // Loop compare keeps the 8-bit index decoupled from the table width.
            for (int i = 0; i < OUTPUT_COUNT; i++) begin
              if (idx_q == 8'(i)) begin
                shadow_sel_d[i*SEL_WIDTH +: SEL_WIDTH] = src_s[SEL_WIDTH-1:0];
                shadow_en_d[i] = rx_data[VAL_EN_BIT];
              end
            end
            dirty_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        act_sel_d = shadow_sel_q;
        act_en_d  = shadow_en_q;
        dirty_d   = 1'b0;
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d != ST_COMMIT);
  end

  // State, tables and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= 8'd0;
      cnt_q        <= '0;
      shadow_sel_q <= '0;
      shadow_en_q  <= '0;
      act_sel_q    <= '0;
      act_en_q     <= '0;
      dirty_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_sel_q <= shadow_sel_d;
      shadow_en_q  <= shadow_en_d;
      act_sel_q    <= act_sel_d;
      act_en_q     <= act_en_d;
      dirty_q      <= dirty_d;
      done_q       <= done_d;
      err_q        <= err_d;
      ready_q      <= ready_d;
    end
  end

  assign rx_ready    = ready_q;
  assign selectors   = act_sel_q;
  assign enabled_out = act_en_q;
  assign cmd_done    = done_q;
  assign cmd_err     = err_q;
  assign dirty       = dirty_q;

endmodule

// File: tb/tb_mux_cfg_loader.sv
// Directed bench for mux_cfg_loader with hand-computed expectations
// (16 inputs, 16 outputs, timeout of 8 idle cycles).
module tb_mux_cfg_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [63:0] selectors;
  logic [15:0] enabled_out;
  logic        cmd_done;
  logic        cmd_err;
  logic        dirty;

  int n_tests = 0;
  int n_fail  = 0;
  int both_cnt = 0;

  mux_cfg_loader #(
    .INPUT_COUNT(16),
    .OUTPUT_COUNT(16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .selectors(selectors),
    .enabled_out(enabled_out),
    .cmd_done(cmd_done),
    .cmd_err(cmd_err),
    .dirty(dirty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmd_done && cmd_err) both_cnt <= both_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Present one byte and hold it until the edge that accepts it; returns 1 ns after that edge.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 10) check_eq("rx_ready_wait", {63'd0, rx_ready}, 64'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick(3);
    check_eq("rst_en", {48'd0, enabled_out}, 64'd0);
    check_eq("rst_sel", selectors, 64'd0);
    check_eq("rst_ready", {63'd0, rx_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);

    // SET out3 <- src15 enabled, then COMMIT
    send(8'h01); send(8'h03); send(8'h8F);
    check_eq("set_done", {63'd0, cmd_done}, 64'd1);
    check_eq("set_dirty", {63'd0, dirty}, 64'd1);
    check_eq("set_en_pre", {48'd0, enabled_out}, 64'd0);
    send(8'h02);
    check_eq("commit_ready_low", {63'd0, rx_ready}, 64'd0);
    check_eq("commit_done_gap", {63'd0, cmd_done}, 64'd0);
    check_eq("commit_en_pending", {48'd0, enabled_out}, 64'd0);
    tick(1);
    check_eq("commit_en", {48'd0, enabled_out}, 64'h0008);
    check_eq("commit_sel", selectors, 64'h0000_0000_0000_F000);
    check_eq("commit_dirty", {63'd0, dirty}, 64'd0);
    check_eq("commit_done", {63'd0, cmd_done}, 64'd1);
    tick(1);
    check_eq("commit_done_1cyc", {63'd0, cmd_done}, 64'd0);

    // Range errors on index and source
    send(8'h01); send(8'h10); send(8'h81);
    check_eq("idx_range_err", {63'd0, cmd_err}, 64'd1);
    check_eq("idx_range_dirty", {63'd0, dirty}, 64'd0);
    send(8'h01); send(8'h02); send(8'h90);
    check_eq("src_range_err", {63'd0, cmd_err}, 64'd1);
    check_eq("src_range_nodone", {63'd0, cmd_done}, 64'd0);
    send(8'h02); tick(1);
    check_eq("range_en_kept", {48'd0, enabled_out}, 64'h0008);
    check_eq("range_sel_kept", selectors, 64'h0000_0000_0000_F000);

    // Bad opcode then a normal SET/COMMIT
    send(8'h7E);
    check_eq("badop_err", {63'd0, cmd_err}, 64'd1);
    check_eq("badop_ready", {63'd0, rx_ready}, 64'd1);
    send(8'h01); send(8'h00); send(8'h82);
    send(8'h02); tick(1);
    check_eq("badop_en", {48'd0, enabled_out}, 64'h0009);
    check_eq("badop_sel", selectors, 64'h0000_0000_0000_F002);

    // Timeout in GET_VAL after 8 idle cycles
    send(8'h01); send(8'h05);
    tick(7);
    check_eq("to_early", {63'd0, cmd_err}, 64'd0);
    tick(1);
    check_eq("to_err", {63'd0, cmd_err}, 64'd1);
    tick(1);
    check_eq("to_err_1cyc", {63'd0, cmd_err}, 64'd0);
    send(8'h8F);
    check_eq("to_resync_err", {63'd0, cmd_err}, 64'd1);
    check_eq("to_no_dirty", {63'd0, dirty}, 64'd0);

    // Back-to-back stream across COMMIT, then CLEAR/COMMIT
    send(8'h02);
    check_eq("b2b_ready_low", {63'd0, rx_ready}, 64'd0);
    send(8'h01);
    check_eq("b2b_commit_done", {63'd0, cmd_done}, 64'd0);
    send(8'h04); send(8'h83);
    check_eq("b2b_set_done", {63'd0, cmd_done}, 64'd1);
    send(8'h03);
    check_eq("clear_done", {63'd0, cmd_done}, 64'd1);
    check_eq("clear_dirty", {63'd0, dirty}, 64'd1);
    check_eq("clear_en_kept", {48'd0, enabled_out}, 64'h0009);
    send(8'h02); tick(1);
    check_eq("clear_commit_en", {48'd0, enabled_out}, 64'd0);
    check_eq("clear_commit_sel", selectors, 64'd0);

    // Async reset mid-cycle with live state
    send(8'h01); send(8'h07); send(8'h85);
    send(8'h02); tick(1);
    check_eq("pre_rst_en", {48'd0, enabled_out}, 64'h0080);
    send(8'h01); send(8'h01); send(8'h81);
    send(8'h01);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_en", {48'd0, enabled_out}, 64'd0);
    check_eq("arst_sel", selectors, 64'd0);
    check_eq("arst_ready", {63'd0, rx_ready}, 64'd1);
    check_eq("arst_dirty", {63'd0, dirty}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    send(8'h02); tick(1);
    check_eq("arst_shadow_clear", {48'd0, enabled_out}, 64'd0);

    check_eq("done_err_excl", both_cnt, 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
